// File: rtl/player_ship_pkg.sv
// player_ship_pkg: shared ship state type, screen geometry, sprite half-sizes and colours.
package player_ship_pkg;
    typedef enum logic [1:0] {ST_ALIVE, ST_HIT, ST_DEAD} ship_state_t;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SCORE_H = 60;
    localparam int SHIP_HALF_W = 20;
    localparam int SHIP_X0 = SCREEN_W / 2;
    localparam int SHIP_Y_BOT = SCREEN_H - 50;
    localparam int SHIP_Y_TOP = SHIP_Y_BOT - 10;
    localparam int SHIP_HIT_Y = SHIP_Y_TOP - 5;
    localparam int LASER_Y0 = SHIP_Y_TOP - 3;
    localparam int LASER_HALF_W = 1;
    localparam int LASER_HALF_H = 5;
    localparam int LASER_FLOOR = SCORE_H + 6;
    localparam int ALIEN_HALF_W = 15;
    localparam int ALIEN_HALF_H = 8;
    localparam logic [7:0] RGB_SHIP = 8'b01111000;
    localparam logic [7:0] RGB_LASER = 8'hFF;

    // |a-c| <= h without wrap, using 11-bit zero-extended operands
    function automatic logic near(input logic [9:0] a, input logic [9:0] c, input int h);
        return ({1'b0, a} + 11'(h) >= {1'b0, c}) && ({1'b0, a} <= {1'b0, c} + 11'(h));
    endfunction
endpackage

// File: rtl/player_ship_shot_slot.sv
// ship_shot_slot: one player laser slot; launch, upward motion and retirement.
module ship_shot_slot
    import player_ship_pkg::*;
#(
    parameter int NUM_ALIENS = 3,
    parameter int LASER_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_tick,
    input  logic                    i_kill,
    input  logic                    i_launch,
    input  logic                    i_barr_hit,
    input  logic [9:0]              i_ship_x,
    input  logic [10*NUM_ALIENS-1:0] i_alien_x,
    input  logic [10*NUM_ALIENS-1:0] i_alien_y,
    output logic [9:0]              o_x,
    output logic [9:0]              o_y,
    output logic                    o_active,
    output logic [NUM_ALIENS-1:0]   o_hit
);
    logic                  r_active;
    logic [9:0]            r_x, r_y;
    logic [NUM_ALIENS-1:0] w_box;
    logic                  w_floor;

    always_comb begin
        w_box = '0;
        for (int k = NUM_ALIENS - 1; k >= 0; k--)
            if ({1'b0, r_y} <= {1'b0, i_alien_y[10*k +: 10]} + 11'(ALIEN_HALF_H + LASER_STEP - 1) &&
                near(r_x, i_alien_x[10*k +: 10], ALIEN_HALF_W)) begin
                w_box    = '0;
                w_box[k] = 1'b1;
            end
        w_floor = {1'b0, r_y} <= 11'(LASER_FLOOR + LASER_STEP - 1);
        o_hit   = (r_active && i_tick && !i_barr_hit && !i_kill && !w_floor) ? w_box : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_active <= 1'b0;
            r_x      <= 10'(SHIP_X0);
            r_y      <= 10'(LASER_Y0);
        end else if (i_clr) begin
            r_active <= 1'b0;
            r_x      <= 10'(SHIP_X0);
            r_y      <= 10'(LASER_Y0);
        end else if (!r_active) begin
            if (i_launch) begin
                r_active <= 1'b1;
                r_x      <= i_ship_x;
                r_y      <= 10'(LASER_Y0);
            end
        end else if (i_barr_hit || i_kill || (i_tick && (w_floor || |w_box)))
            r_active <= 1'b0;
        else if (i_tick)
            r_y <= r_y - 10'(LASER_STEP);

    // an idle slot sits on the ship so a launch always starts from the nose
    assign o_x      = r_active ? r_x : i_ship_x;
    assign o_y      = r_active ? r_y : 10'(LASER_Y0);
    assign o_active = r_active;
endmodule

// File: rtl/player_ship.sv
// player_ship: ship FSM, movement, shot allocation, alien-kill arbitration and sprite display.
module player_ship
    import player_ship_pkg::*;
#(
    parameter int NUM_SHOTS        = 3,
    parameter int NUM_ALIENS       = 3,
    parameter int NUM_ALIEN_LASERS = 3,
    parameter int MOVE_STEP        = 1,
    parameter int LASER_STEP       = 1,
    parameter int LIVES            = 3,
    parameter int HIT_FRAMES       = 64,
    parameter int COOLDOWN_FRAMES  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic                          button_left,
    input  logic                          button_right,
    input  logic                          button_shoot,
    input  logic [9:0]                    xCoord,
    input  logic [9:0]                    yCoord,
    input  logic [10*NUM_ALIENS-1:0]       alien_xCoord,
    input  logic [10*NUM_ALIENS-1:0]       alien_yCoord,
    input  logic [10*NUM_ALIEN_LASERS-1:0] alien_laser_xCoord,
    input  logic [10*NUM_ALIEN_LASERS-1:0] alien_laser_yCoord,
    input  logic [NUM_SHOTS-1:0]          barr_hit,
    output logic [7:0]                    rgb,
    output logic [7:0]                    rgb_laser,
    output logic                          is_spaceship,
    output logic                          is_laser,
    output logic [10*NUM_SHOTS-1:0]       laser_xCoord,
    output logic [10*NUM_SHOTS-1:0]       laser_yCoord,
    output logic [NUM_SHOTS-1:0]          shot_active,
    output logic [NUM_ALIENS-1:0]         alien_hit,
    output logic [3:0]                    lives,
    output logic                          can_move,
    output logic                          game_over
);
    ship_state_t           r_state, w_state_nxt;
    logic [9:0]            r_ship_x;
    logic [3:0]            r_lives;
    logic [15:0]           r_cooldown, r_frame_cnt;
    logic                  r_shoot_prev;
    logic [NUM_ALIENS-1:0] r_alien_hit, w_alien_hit;
    logic [NUM_ALIENS-1:0] w_slot_hit [NUM_SHOTS];
    logic [NUM_SHOTS-1:0]  w_launch;
    logic                  w_tick, w_clr, w_dead, w_ship_hit, w_hit_done, w_fire, w_found;

    assign w_tick     = xCoord == 10'd0 && yCoord == 10'd0;
    assign w_clr      = !mode;
    assign w_dead     = r_state == ST_DEAD;
    assign w_hit_done = w_tick && r_frame_cnt == 16'(HIT_FRAMES - 1);
    assign w_fire     = w_tick && button_shoot && !r_shoot_prev && r_state == ST_ALIVE && r_cooldown == 16'd0;

    always_comb begin
        w_ship_hit = 1'b0;
        for (int j = 0; j < NUM_ALIEN_LASERS; j++)
            w_ship_hit = w_ship_hit | (({1'b0, alien_laser_yCoord[10*j +: 10]} >= 11'(SHIP_HIT_Y)) &&
                         near(alien_laser_xCoord[10*j +: 10], r_ship_x, SHIP_HALF_W));
        w_launch = '0;
        for (int s = NUM_SHOTS - 1; s >= 0; s--)
            if (w_fire && !shot_active[s]) begin
                w_launch    = '0;
                w_launch[s] = 1'b1;
            end
        w_found     = |w_launch;
        w_alien_hit = '0;
        for (int s = 0; s < NUM_SHOTS; s++)
            w_alien_hit = w_alien_hit | w_slot_hit[s];
        w_state_nxt = r_state;
        if (r_state == ST_ALIVE && w_tick && w_ship_hit)
            w_state_nxt = ST_HIT;
        if (r_state == ST_HIT && w_hit_done)
            w_state_nxt = (r_lives != 4'd0) ? ST_ALIVE : ST_DEAD;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_state <= ST_ALIVE;
        else
            r_state <= w_clr ? ST_ALIVE : w_state_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_ship_x     <= 10'(SHIP_X0);
            r_lives      <= 4'(LIVES);
            r_cooldown   <= '0;
            r_frame_cnt  <= '0;
            r_shoot_prev <= 1'b0;
            r_alien_hit  <= '0;
        end else if (w_clr) begin
            r_ship_x     <= 10'(SHIP_X0);
            r_lives      <= 4'(LIVES);
            r_cooldown   <= '0;
            r_frame_cnt  <= '0;
            r_shoot_prev <= 1'b0;
            r_alien_hit  <= '0;
        end else begin
            r_alien_hit <= w_alien_hit;
            if (w_tick) begin
                r_shoot_prev <= button_shoot;
                r_cooldown   <= w_found ? 16'(COOLDOWN_FRAMES) : (r_cooldown != 16'd0 ? r_cooldown - 16'd1 : 16'd0);
                r_frame_cnt  <= (r_state == ST_HIT && !w_hit_done) ? r_frame_cnt + 16'd1 : 16'd0;
                if (r_state == ST_ALIVE && w_ship_hit)
                    r_lives <= (r_lives != 4'd0) ? r_lives - 4'd1 : 4'd0;
                if (r_state == ST_HIT && w_hit_done)
                    r_ship_x <= 10'(SHIP_X0);
                else if (r_state == ST_ALIVE && button_left && !button_right)
                    r_ship_x <= (r_ship_x > 10'(SHIP_HALF_W + MOVE_STEP - 1)) ? r_ship_x - 10'(MOVE_STEP) : 10'(SHIP_HALF_W);
                else if (r_state == ST_ALIVE && button_right && !button_left)
                    r_ship_x <= (r_ship_x < 10'(SCREEN_W - SHIP_HALF_W - MOVE_STEP + 1)) ? r_ship_x + 10'(MOVE_STEP) : 10'(SCREEN_W - SHIP_HALF_W);
            end
        end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
        ship_shot_slot #(.NUM_ALIENS(NUM_ALIENS), .LASER_STEP(LASER_STEP)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clr      (w_clr),
            .i_tick     (w_tick),
            .i_kill     (w_dead),
            .i_launch   (w_launch[i]),
            .i_barr_hit (barr_hit[i]),
            .i_ship_x   (r_ship_x),
            .i_alien_x  (alien_xCoord),
            .i_alien_y  (alien_yCoord),
            .o_x        (laser_xCoord[10*i +: 10]),
            .o_y        (laser_yCoord[10*i +: 10]),
            .o_active   (shot_active[i]),
            .o_hit      (w_slot_hit[i])
        );
    end

    always_comb begin
        is_laser = 1'b0;
        for (int s = 0; s < NUM_SHOTS; s++)
            is_laser = is_laser | (shot_active[s] && near(yCoord, laser_yCoord[10*s +: 10], LASER_HALF_H) &&
                       near(xCoord, laser_xCoord[10*s +: 10], LASER_HALF_W));
    end

    // the ship blinks during HIT on bit 3 of the frame counter
    assign is_spaceship = (r_state == ST_ALIVE || (r_state == ST_HIT && !r_frame_cnt[3])) &&
                          {1'b0, yCoord} >= 11'(SHIP_Y_TOP) && {1'b0, yCoord} <= 11'(SHIP_Y_BOT) &&
                          near(xCoord, r_ship_x, SHIP_HALF_W);
    assign rgb       = RGB_SHIP;
    assign rgb_laser = RGB_LASER;
    assign alien_hit = r_alien_hit;
    assign lives     = r_lives;
    assign can_move  = r_state == ST_ALIVE;
    assign game_over = r_state == ST_DEAD;
endmodule

// File: tb/tb_player_ship.sv
// tb_player_ship: directed checks of movement, shots, kills, barrier hits, ship hits and reset.
module tb_player_ship;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mode = 1'b1;
    logic        button_left = 1'b0, button_right = 1'b0, button_shoot = 1'b0;
    logic [9:0]  xCoord = 10'd5, yCoord = 10'd5;
    logic [29:0] alien_xCoord = '0, alien_yCoord = '0;
    logic [29:0] alien_laser_xCoord = '0, alien_laser_yCoord = '0;
    logic [2:0]  barr_hit = '0;
    logic [7:0]  rgb, rgb_laser;
    logic        is_spaceship, is_laser;
    logic [29:0] laser_xCoord, laser_yCoord;
    logic [2:0]  shot_active, alien_hit;
    logic [3:0]  lives;
    logic        can_move, game_over;
    int          n_checks = 0;
    int          n_fail = 0;

    player_ship dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .button_left(button_left), .button_right(button_right), .button_shoot(button_shoot),
        .xCoord(xCoord), .yCoord(yCoord),
        .alien_xCoord(alien_xCoord), .alien_yCoord(alien_yCoord),
        .alien_laser_xCoord(alien_laser_xCoord), .alien_laser_yCoord(alien_laser_yCoord),
        .barr_hit(barr_hit), .rgb(rgb), .rgb_laser(rgb_laser),
        .is_spaceship(is_spaceship), .is_laser(is_laser),
        .laser_xCoord(laser_xCoord), .laser_yCoord(laser_yCoord),
        .shot_active(shot_active), .alien_hit(alien_hit),
        .lives(lives), .can_move(can_move), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one frame = a tick cycle followed by an ordinary pixel cycle
    task automatic frame(input int n);
        for (int f = 0; f < n; f++) begin
            @(negedge clk); xCoord = 10'd0; yCoord = 10'd0;
            @(negedge clk); xCoord = 10'd5; yCoord = 10'd5;
        end
    endtask

    task automatic press();
        button_shoot = 1'b1; frame(1); button_shoot = 1'b0;
    endtask

    task automatic enemy(input logic [9:0] x, input logic [9:0] y);
        alien_laser_xCoord[9:0] = x; alien_laser_yCoord[9:0] = y;
        frame(1);
        alien_laser_xCoord = '0; alien_laser_yCoord = '0;
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        xCoord = x; yCoord = y; #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_lives", lives, 3);
        check("rst_can_move", can_move, 1);
        check("rst_game_over", game_over, 0);
        check("rst_shot_active", shot_active, 0);
        check("rst_alien_hit", alien_hit, 0);
        check("rst_x0", laser_xCoord[9:0], 320);
        check("rst_y0", laser_yCoord[9:0], 417);
        check("rgb", rgb, 8'b01111000);
        check("rgb_laser", rgb_laser, 8'hFF);
        pixel(10'd320, 10'd425);
        check("rst_ship_pix", is_spaceship, 1);
        pixel(10'd320, 10'd417);
        check("rst_no_laser_pix", is_laser, 0);
        pixel(10'd5, 10'd5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        button_right = 1'b1; frame(299);
        check("right_619", laser_xCoord[9:0], 619);
        frame(11);
        check("right_clamp_620", laser_xCoord[9:0], 620);
        button_right = 1'b0; button_left = 1'b1; frame(700);
        check("left_clamp_20", laser_xCoord[9:0], 20);
        button_left = 1'b0;
        @(negedge clk); mode = 1'b0;
        @(negedge clk); mode = 1'b1;
        check("soft_rst_x", laser_xCoord[9:0], 320);

        press();
        check("p1_active", shot_active, 3'b001);
        check("p1_y0", laser_yCoord[9:0], 417);
        pixel(10'd321, 10'd422);
        check("laser_pix_edge", is_laser, 1);
        pixel(10'd322, 10'd422);
        check("laser_pix_out", is_laser, 0);
        frame(19); press();
        check("p2_active", shot_active, 3'b011);
        check("p2_y0", laser_yCoord[9:0], 397);
        check("p2_y1", laser_yCoord[19:10], 417);
        frame(19); press();
        check("p3_active", shot_active, 3'b111);
        check("p3_y0", laser_yCoord[9:0], 377);
        check("p3_y2", laser_yCoord[29:20], 417);
        frame(19); press();
        check("p4_dropped", shot_active, 3'b111);
        check("p4_y0", laser_yCoord[9:0], 357);
        frame(291);
        check("floor_y0_66", laser_yCoord[9:0], 66);
        check("floor_still_active", shot_active, 3'b111);
        frame(1);
        check("floor_retire", shot_active, 3'b110);
        check("floor_y0_idle", laser_yCoord[9:0], 417);
        check("floor_y1", laser_yCoord[19:10], 85);
        frame(40);
        check("all_retired", shot_active, 3'b000);

        press(); frame(10);
        check("barr_pre_y0", laser_yCoord[9:0], 407);
        barr_hit = 3'b001; frame(1); barr_hit = 3'b000;
        check("barr_retire", shot_active, 3'b000);
        check("barr_y0_idle", laser_yCoord[9:0], 417);
        frame(10);

        alien_xCoord = {10'd0, 10'd320, 10'd0};
        alien_yCoord = {10'd0, 10'd200, 10'd0};
        press(); frame(209);
        check("alien_pre_y0", laser_yCoord[9:0], 208);
        check("alien_pre_hit", alien_hit, 3'b000);
        frame(1);
        check("alien_hit_pulse", alien_hit, 3'b010);
        check("alien_retire", shot_active, 3'b000);
        @(negedge clk);
        check("alien_hit_one_cycle", alien_hit, 3'b000);
        alien_xCoord = {10'd0, 10'd320, 10'd320};
        alien_yCoord = {10'd0, 10'd200, 10'd200};
        press(); frame(210);
        check("alien_lowest_k", alien_hit, 3'b001);
        alien_xCoord = '0; alien_yCoord = '0;
        frame(20);

        button_right = 1'b1; frame(5); button_right = 1'b0;
        press(); frame(5);
        check("mid_active", shot_active, 3'b001);
        check("mid_x0", laser_xCoord[9:0], 325);
        check("mid_x1_tracks", laser_xCoord[19:10], 325);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("async_active", shot_active, 3'b000);
        check("async_x0", laser_xCoord[9:0], 320);
        check("async_y0", laser_yCoord[9:0], 417);
        check("async_lives", lives, 3);
        @(negedge clk); rst_n = 1'b1;

        enemy(10'd341, 10'd416);
        check("miss_right_edge", can_move, 1);
        enemy(10'd299, 10'd416);
        check("miss_left_edge", can_move, 1);
        enemy(10'd320, 10'd414);
        check("miss_high", lives, 3);
        enemy(10'd325, 10'd416);
        check("hit1_can_move", can_move, 0);
        check("hit1_lives", lives, 2);
        pixel(10'd320, 10'd425);
        check("hit1_blink_on", is_spaceship, 1);
        frame(8);
        pixel(10'd320, 10'd425);
        check("hit1_blink_off", is_spaceship, 0);
        frame(55);
        check("hit1_still_hit", can_move, 0);
        frame(1);
        check("hit1_recover", can_move, 1);
        button_right = 1'b1; frame(10); button_right = 1'b0;
        check("hit2_pre_x", laser_xCoord[9:0], 330);
        enemy(10'd345, 10'd416);
        check("hit2_lives", lives, 1);
        frame(64);
        check("hit2_recover", can_move, 1);
        check("hit2_reload_x", laser_xCoord[9:0], 320);
        enemy(10'd325, 10'd416);
        check("hit3_lives", lives, 0);
        frame(64);
        check("dead_game_over", game_over, 1);
        check("dead_can_move", can_move, 0);
        pixel(10'd320, 10'd425);
        check("dead_no_ship", is_spaceship, 0);
        @(negedge clk); mode = 1'b0;
        @(negedge clk); mode = 1'b1;
        check("menu_game_over", game_over, 0);
        check("menu_lives", lives, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
